// File: rtl/mem_wb_load_align_pkg.sv
// Shared definitions for the MEM/WB stage: load funct3 encodings, widths and
// the packed control word carried from MEM into WB.
package mem_wb_load_align_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef struct packed {
        logic                      valid;
        logic                      reg_write;
        logic                      mem_to_reg;
        logic [2:0]                funct3;
        logic [1:0]                byte_off;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } mem_wb_ctrl_t;

endpackage

// File: rtl/mem_wb_load_align_if.sv
// MEM-stage inputs, data-memory read word, WB hazard controls and WB outputs.
// master = pipeline/memory side, slave = the MEM/WB stage itself.
interface mem_wb_load_align_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      MEM_valid_i;
    logic                      MEM_RegWrite_i;
    logic                      MEM_MemToReg_i;
    logic [2:0]                MEM_funct3_i;
    logic [1:0]                MEM_byte_off_i;
    logic [REG_ADDR_WIDTH-1:0] MEM_rd_addr_i;
    logic [DATA_WIDTH-1:0]     MEM_alu_result_i;
    logic [DATA_WIDTH-1:0]     mem_rd_data_i;
    logic                      WB_stall_i;
    logic                      WB_flush_i;
    logic                      WB_valid_o;
    logic                      WB_RegWrite_o;
    logic [REG_ADDR_WIDTH-1:0] WB_rd_addr_o;
    logic [DATA_WIDTH-1:0]     WB_wr_data_o;
    logic                      WB_load_fault_o;

    modport master (
        output MEM_valid_i, MEM_RegWrite_i, MEM_MemToReg_i, MEM_funct3_i,
               MEM_byte_off_i, MEM_rd_addr_i, MEM_alu_result_i, mem_rd_data_i,
               WB_stall_i, WB_flush_i,
        input  WB_valid_o, WB_RegWrite_o, WB_rd_addr_o, WB_wr_data_o, WB_load_fault_o
    );

    modport slave (
        input  MEM_valid_i, MEM_RegWrite_i, MEM_MemToReg_i, MEM_funct3_i,
               MEM_byte_off_i, MEM_rd_addr_i, MEM_alu_result_i, mem_rd_data_i,
               WB_stall_i, WB_flush_i,
        output WB_valid_o, WB_RegWrite_o, WB_rd_addr_o, WB_wr_data_o, WB_load_fault_o
    );

endinterface

// File: rtl/mem_wb_load_align_load_extender.sv
// Combinational load extraction: picks the byte/half/word addressed by the
// offset, sign- or zero-extends it, and flags misaligned or illegal loads.
module load_extender
    import mem_wb_load_align_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] raw_word,
    input  logic [2:0]            funct3,
    input  logic [1:0]            byte_off,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_word[{byte_off, 3'b000} +: 8];
    assign half_sel = raw_word[{byte_off[1], 4'b0000} +: 16];

    // A faulting load returns zero so nothing stale can be forwarded.
    always_comb begin
        load_data = '0;
        fault     = 1'b0;
        case (funct3)
            FUNCT3_LB:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            FUNCT3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            FUNCT3_LH: begin
                if (byte_off[0]) fault = 1'b1;
                else             load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            end
            FUNCT3_LHU: begin
                if (byte_off[0]) fault = 1'b1;
                else             load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            end
            FUNCT3_LW: begin
                if (byte_off != 2'b00) fault = 1'b1;
                else                   load_data = raw_word;
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_load_align.sv
// MEM/WB pipeline register with load alignment, a stall hold buffer for the
// synchronous memory's read word, and register-file write qualification.
module mem_wb_load_align
    import mem_wb_load_align_pkg::*;
#(
    parameter int DATA_WIDTH     = mem_wb_load_align_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mem_wb_load_align_pkg::REG_ADDR_WIDTH
) (
    input logic               clk,
    input logic               rst,
    mem_wb_load_align_if.slave bus
);

    mem_wb_ctrl_t          mem_ctrl;
    mem_wb_ctrl_t          wb_ctrl;
    logic [DATA_WIDTH-1:0] wb_alu;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] raw_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  ext_fault;
    logic                  load_fault;
    logic                  rd_nonzero;

    always_comb begin
        mem_ctrl            = '0;
        mem_ctrl.valid      = bus.MEM_valid_i & ~bus.WB_flush_i;
        mem_ctrl.reg_write  = bus.MEM_RegWrite_i;
        mem_ctrl.mem_to_reg = bus.MEM_MemToReg_i;
        mem_ctrl.funct3     = bus.MEM_funct3_i;
        mem_ctrl.byte_off   = bus.MEM_byte_off_i;
        mem_ctrl.rd         = bus.MEM_rd_addr_i;
    end

    // The memory word is only valid for one cycle, so the first stalled edge
    // of a live load snapshots it; flush still kills the slot while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ctrl    <= '0;
            wb_alu     <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else begin
            if (!bus.WB_stall_i) begin
                wb_ctrl    <= mem_ctrl;
                wb_alu     <= bus.MEM_alu_result_i;
                hold_valid <= 1'b0;
            end else begin
                if (bus.WB_flush_i) wb_ctrl.valid <= 1'b0;
                if (!hold_valid && wb_ctrl.valid && wb_ctrl.mem_to_reg) begin
                    hold_data  <= bus.mem_rd_data_i;
                    hold_valid <= 1'b1;
                end
            end
        end
    end

    assign raw_word = hold_valid ? hold_data : bus.mem_rd_data_i;

    load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_load_extender (
        .raw_word  (raw_word),
        .funct3    (wb_ctrl.funct3),
        .byte_off  (wb_ctrl.byte_off),
        .load_data (load_data),
        .fault     (ext_fault)
    );

    assign load_fault = wb_ctrl.valid & wb_ctrl.mem_to_reg & ext_fault;
    assign rd_nonzero = (wb_ctrl.rd != {REG_ADDR_WIDTH{1'b0}});

    assign bus.WB_valid_o      = wb_ctrl.valid;
    assign bus.WB_rd_addr_o    = wb_ctrl.rd;
    assign bus.WB_load_fault_o = load_fault;
    assign bus.WB_wr_data_o    = wb_ctrl.mem_to_reg ? load_data : wb_alu;
    assign bus.WB_RegWrite_o   = wb_ctrl.valid & wb_ctrl.reg_write & ~load_fault & rd_nonzero;

endmodule

// File: tb/tb_mem_wb_load_align.sv
// Scoreboard bench for mem_wb_load_align: directed loads/ALU ops push expected
// WB results; a negedge monitor pops and compares whenever WB_valid_o is high.
module tb_mem_wb_load_align;
    import mem_wb_load_align_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        reg_write;
        logic        fault;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mem_wb_load_align_if #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) bus ();

    mem_wb_load_align #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endfunction

    // Issue one MEM instruction; the read word appears in its WB cycle.
    task automatic applyStimulus(input logic rw, input logic m2r, input logic [2:0] f3,
                                 input logic [1:0] off, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] word,
                                 input logic [31:0] exp_data, input logic exp_rw,
                                 input logic exp_fault);
        bus.MEM_valid_i      = 1'b1;
        bus.MEM_RegWrite_i   = rw;
        bus.MEM_MemToReg_i   = m2r;
        bus.MEM_funct3_i     = f3;
        bus.MEM_byte_off_i   = off;
        bus.MEM_rd_addr_i    = rd;
        bus.MEM_alu_result_i = alu;
        bus.WB_stall_i       = 1'b0;
        bus.WB_flush_i       = 1'b0;
        @(posedge clk);
        #1;
        bus.mem_rd_data_i = word;
        bus.MEM_valid_i   = 1'b0;
        exp_q.push_back('{exp_data, exp_rw, exp_fault, rd});
    endtask

    task automatic idleCycle();
        bus.MEM_valid_i = 1'b0;
        bus.WB_stall_i  = 1'b0;
        bus.WB_flush_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.WB_valid_o) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_valid: got WB_valid_o=1 with data 0x%08h, required no live WB slot",
                         bus.WB_wr_data_o);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_data",  bus.WB_wr_data_o, e.data);
                checkOutput("regwrite", {31'b0, bus.WB_RegWrite_o}, {31'b0, e.reg_write});
                checkOutput("fault",    {31'b0, bus.WB_load_fault_o}, {31'b0, e.fault});
                checkOutput("rd_addr",  {27'b0, bus.WB_rd_addr_o}, {27'b0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.MEM_valid_i      = 1'b0;
        bus.MEM_RegWrite_i   = 1'b0;
        bus.MEM_MemToReg_i   = 1'b0;
        bus.MEM_funct3_i     = 3'b000;
        bus.MEM_byte_off_i   = 2'b00;
        bus.MEM_rd_addr_i    = 5'd0;
        bus.MEM_alu_result_i = 32'h0;
        bus.mem_rd_data_i    = 32'h0;
        bus.WB_stall_i       = 1'b0;
        bus.WB_flush_i       = 1'b0;
        #2;
        checkOutput("reset_valid",    {31'b0, bus.WB_valid_o}, 32'h0);
        checkOutput("reset_regwrite", {31'b0, bus.WB_RegWrite_o}, 32'h0);
        checkOutput("reset_data",     bus.WB_wr_data_o, 32'h0);
        checkOutput("reset_fault",    {31'b0, bus.WB_load_fault_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Byte loads from 0x80FF_7F01
        applyStimulus(1, 1, FUNCT3_LB,  2'd3, 5'd1, 32'h100, 32'h80FF_7F01, 32'hFFFF_FF80, 1, 0);
        applyStimulus(1, 1, FUNCT3_LBU, 2'd3, 5'd2, 32'h100, 32'h80FF_7F01, 32'h0000_0080, 1, 0);
        applyStimulus(1, 1, FUNCT3_LB,  2'd2, 5'd3, 32'h100, 32'h80FF_7F01, 32'hFFFF_FFFF, 1, 0);
        applyStimulus(1, 1, FUNCT3_LB,  2'd1, 5'd4, 32'h100, 32'h80FF_7F01, 32'h0000_007F, 1, 0);
        applyStimulus(1, 1, FUNCT3_LBU, 2'd0, 5'd5, 32'h100, 32'h80FF_7F01, 32'h0000_0001, 1, 0);
        // Half loads from 0x8001_1234
        applyStimulus(1, 1, FUNCT3_LH,  2'd2, 5'd6, 32'h200, 32'h8001_1234, 32'hFFFF_8001, 1, 0);
        applyStimulus(1, 1, FUNCT3_LHU, 2'd2, 5'd7, 32'h200, 32'h8001_1234, 32'h0000_8001, 1, 0);
        applyStimulus(1, 1, FUNCT3_LH,  2'd0, 5'd8, 32'h200, 32'h8001_1234, 32'h0000_1234, 1, 0);
        // Word load, misaligned/illegal loads, ALU ops
        applyStimulus(1, 1, FUNCT3_LW,  2'd0, 5'd9,  32'h300, 32'h1234_5678, 32'h1234_5678, 1, 0);
        applyStimulus(1, 1, FUNCT3_LW,  2'd1, 5'd10, 32'h301, 32'h1234_5678, 32'h0000_0000, 0, 1);
        applyStimulus(1, 1, FUNCT3_LH,  2'd3, 5'd11, 32'h303, 32'h1234_5678, 32'h0000_0000, 0, 1);
        applyStimulus(1, 1, FUNCT3_LHU, 2'd1, 5'd12, 32'h301, 32'h1234_5678, 32'h0000_0000, 0, 1);
        applyStimulus(1, 1, 3'b011,     2'd0, 5'd13, 32'h300, 32'h1234_5678, 32'h0000_0000, 0, 1);
        applyStimulus(1, 0, FUNCT3_LW,  2'd3, 5'd14, 32'h0000_0ABC, 32'h1234_5678, 32'h0000_0ABC, 1, 0);
        applyStimulus(1, 0, FUNCT3_LB,  2'd0, 5'd0,  32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 0, 0);
        applyStimulus(0, 1, FUNCT3_LW,  2'd0, 5'd15, 32'h400, 32'h5555_AAAA, 32'h5555_AAAA, 0, 0);

        // Stall hold: three stalled WB cycles, memory word changes after the first
        applyStimulus(1, 1, FUNCT3_LW, 2'd0, 5'd16, 32'h500, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        bus.WB_stall_i = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_rd_data_i = 32'h1111_1111;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0, 5'd16});
        @(posedge clk);
        #1;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b1, 1'b0, 5'd16});
        applyStimulus(1, 0, FUNCT3_LW, 2'd0, 5'd17, 32'h1234_ABCD, 32'h0, 32'h1234_ABCD, 1, 0);

        // Flush together with stall kills the WB slot
        applyStimulus(1, 0, FUNCT3_LW, 2'd0, 5'd18, 32'h0000_0099, 32'h0, 32'h0000_0099, 1, 0);
        bus.MEM_valid_i = 1'b1;
        bus.WB_stall_i  = 1'b1;
        bus.WB_flush_i  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_stall_valid",    {31'b0, bus.WB_valid_o}, 32'h0);
        checkOutput("flush_stall_regwrite", {31'b0, bus.WB_RegWrite_o}, 32'h0);
        // Flush alone on the entering instruction
        bus.WB_stall_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flush_valid", {31'b0, bus.WB_valid_o}, 32'h0);
        idleCycle();

        // Reset mid-stall: outputs drop at once, hold buffer discarded
        applyStimulus(1, 1, FUNCT3_LW, 2'd0, 5'd19, 32'h600, 32'hAAAA_5555, 32'hAAAA_5555, 1, 0);
        bus.WB_stall_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid",    {31'b0, bus.WB_valid_o}, 32'h0);
        checkOutput("midrst_regwrite", {31'b0, bus.WB_RegWrite_o}, 32'h0);
        checkOutput("midrst_data",     bus.WB_wr_data_o, 32'h0);
        checkOutput("midrst_fault",    {31'b0, bus.WB_load_fault_o}, 32'h0);
        bus.WB_stall_i    = 1'b0;
        bus.mem_rd_data_i = 32'h7777_7777;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idleCycle();
            checkOutput("post_rst_regwrite", {31'b0, bus.WB_RegWrite_o}, 32'h0);
        end
        applyStimulus(1, 1, FUNCT3_LW, 2'd0, 5'd20, 32'h700, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0);

        idleCycle();
        idleCycle();
        checkOutput("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
